dma_pcie_rd_req_gen: RTL and testbench
======================================

// Module: dma_pcie_rd_req_gen
// PURPOSE
// Multi-channel PCIe read-request generator for the UltraScale read DMA path.
// Round-robin arbitrates PORTS read-descriptor inputs and splits each descriptor at max_read_request_size and 4 KB boundaries.
// Allocates a PCIe tag per request from a free pool and gates issue on NPH flow-control credits and an in-flight TX limit.
// Emits one header-field record per memory-read TLP to the RQ formatter; completion-side logic returns tags.
// PARAMETERS
// PORTS            2   number of descriptor input channels (1..8)
// PCIE_ADDR_WIDTH  64  PCIe address width
// LEN_WIDTH        16  descriptor byte-length width
// TAG_WIDTH        8   descriptor tag width
// PCIE_TAG_COUNT   64  tag pool size (32, 64 or 256); PCIE_TAG_WIDTH = $clog2(PCIE_TAG_COUNT)
// TX_LIMIT         8   max requests issued but not yet reported by tx_done
// TX_FC_ENABLE     1   1: gate issue on pcie_tx_fc_nph_av
// PORTS
// clk                         in   1                   clock
// rst                         in   1                   synchronous active-high reset
// s_axis_read_desc_pcie_addr  in   PORTS*PCIE_ADDR_WIDTH  per-port start address
// s_axis_read_desc_len        in   PORTS*LEN_WIDTH     per-port byte length
// s_axis_read_desc_tag        in   PORTS*TAG_WIDTH     per-port descriptor tag
// s_axis_read_desc_valid      in   PORTS               per-port valid
// s_axis_read_desc_ready      out  PORTS               per-port ready
// m_axis_req_pcie_addr        out  PCIE_ADDR_WIDTH     request address, dword aligned ([1:0]=0)
// m_axis_req_dword_count      out  11                  request length in dwords (1..1024)
// m_axis_req_first_be         out  4                   first-dword byte enables
// m_axis_req_last_be          out  4                   last-dword byte enables
// m_axis_req_pcie_tag         out  PCIE_TAG_WIDTH      allocated PCIe tag
// m_axis_req_valid/_ready     out/in 1                 request handshake
// s_axis_tag_release_tag      in   PCIE_TAG_WIDTH      tag freed by completion logic
// s_axis_tag_release_valid    in   1                   release strobe
// tx_done                     in   1                   one pulse per request sent on link (seq-num return)
// pcie_tx_fc_nph_av           in   8                   available NP header credits
// m_axis_split_status_port    out  $clog2(PORTS) (min 1)  port of finished descriptor
// m_axis_split_status_tag     out  TAG_WIDTH           tag of finished descriptor
// m_axis_split_status_count   out  LEN_WIDTH           requests generated for it
// m_axis_split_status_valid   out  1                   one-cycle status pulse
// enable, ext_tag_enable      in   1                   accept enable; 1: use full pool, 0: tags 0..31 only
// max_read_request_size       in   3                   MRRS code; bytes = 128<<code, codes >5 clamp to 4096
// status_busy, status_tag_error out 1                 descriptor in progress; bad release pulse
// BEHAVIOUR
// Reset: all outputs 0, state IDLE, every tag free, TX counter 0, RR pointer at port 0.
// FSM IDLE: if enable, grant the first valid port after the last granted (round robin); assert its ready for exactly one cycle; latch addr/len/tag; -> ISSUE. len=0 -> STATUS with count 0.
// FSM ISSUE: bytes = min(remaining, MRRS bytes, 4096-addr[11:0]); dword_count = (addr[1:0]+bytes+3)>>2.
//   first_be = 4'hF<<addr[1:0]; last_be = 4'hF>>((4-end[1:0])&3), end = addr+bytes.
//   If dword_count=1: first_be &= last_be, last_be=0.
//   Assert valid only when a tag is free, tx_count<TX_LIMIT, and (TX_FC_ENABLE=0 or nph_av>=2).
//   On assertion, allocate the lowest free tag; hold valid and all fields stable until ready.
//   On accept: addr+=bytes, remaining-=bytes, count++, tx_count++; remaining=0 -> STATUS.
// FSM STATUS: status_valid=1 for one cycle with port/tag/count -> IDLE. Next grant is possible on the following cycle.
// tx_count: simultaneous issue and tx_done nets to 0. tx_done at tx_count=0 is ignored.
// Tag release: sets the free bit. Releasing an already-free or out-of-range tag: no state change, status_tag_error pulses 1 cycle.
//   Release and allocation of the same tag in one cycle: allocation sees the tag as not yet free.
// enable falling mid-descriptor: current descriptor completes, no new grant.
// Reset mid-operation: drops the in-flight descriptor without status and frees all tags.
// status_busy = (state != IDLE).
// TESTING
// 1. Port 0, addr 0x1000, len 512, MRRS code 1 (256 B) -> 2 requests: 0x1000/64dw, 0x1100/64dw; BE F/F; status count 2.
// 2. Addr 0x0FFE, len 8 -> requests 0x0FFC (dw1, first_be C, last_be 0) and 0x1000 (dw2, first_be F, last_be 3).
// 3. Ports 0 and 1 both valid for 4 descriptors -> grants alternate 0,1,0,1; each ready is a single-cycle pulse.
// 4. ext_tag_enable=0, no releases, 40 single-dword requests -> 32 issued with tags 0..31, then valid stalls.
//    Release tag 5 -> next request uses tag 5. Release of tag 5 again -> status_tag_error pulse.
// 5. TX_LIMIT=8 and tx_done held 0 -> 8 issued, then stall; one tx_done pulse -> exactly one more issued.
//    nph_av=1 -> no issue until it rises to 2.
// 6. Assert rst during ISSUE with ready=0 -> next cycle valid=0, busy=0, all tags free, no status pulse.

Source files
------------

// File: rtl/dma_pcie_rd_req_gen.sv
// Multi-channel PCIe read-request generator: round-robin descriptor intake,
// MRRS/4KB splitting, tag pool, NPH-credit and in-flight TX gating.
// Ports: s_axis_read_desc_* (per-port descriptors), m_axis_req_* (one record
// per MRd TLP), s_axis_tag_release_* (tag return), tx_done/pcie_tx_fc_nph_av
// (issue gating), m_axis_split_status_* (per-descriptor summary), config/status.
module dma_pcie_rd_req_gen #(
    parameter int PORTS           = 2,
    parameter int PCIE_ADDR_WIDTH = 64,
    parameter int LEN_WIDTH       = 16,
    parameter int TAG_WIDTH       = 8,
    parameter int PCIE_TAG_COUNT  = 64,
    parameter int TX_LIMIT        = 8,
    parameter int TX_FC_ENABLE    = 1,
    localparam int PCIE_TAG_WIDTH = $clog2(PCIE_TAG_COUNT),
    localparam int PW             = (PORTS > 1) ? $clog2(PORTS) : 1
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [PORTS*PCIE_ADDR_WIDTH-1:0] s_axis_read_desc_pcie_addr,
    input  logic [PORTS*LEN_WIDTH-1:0]    s_axis_read_desc_len,
    input  logic [PORTS*TAG_WIDTH-1:0]    s_axis_read_desc_tag,
    input  logic [PORTS-1:0]              s_axis_read_desc_valid,
    output logic [PORTS-1:0]              s_axis_read_desc_ready,
    output logic [PCIE_ADDR_WIDTH-1:0]    m_axis_req_pcie_addr,
    output logic [10:0]                   m_axis_req_dword_count,
    output logic [3:0]                    m_axis_req_first_be,
    output logic [3:0]                    m_axis_req_last_be,
    output logic [PCIE_TAG_WIDTH-1:0]     m_axis_req_pcie_tag,
    output logic                          m_axis_req_valid,
    input  logic                          m_axis_req_ready,
    input  logic [PCIE_TAG_WIDTH-1:0]     s_axis_tag_release_tag,
    input  logic                          s_axis_tag_release_valid,
    input  logic                          tx_done,
    input  logic [7:0]                    pcie_tx_fc_nph_av,
    output logic [PW-1:0]                 m_axis_split_status_port,
    output logic [TAG_WIDTH-1:0]          m_axis_split_status_tag,
    output logic [LEN_WIDTH-1:0]          m_axis_split_status_count,
    output logic                          m_axis_split_status_valid,
    input  logic                          enable,
    input  logic                          ext_tag_enable,
    input  logic [2:0]                    max_read_request_size,
    output logic                          status_busy,
    output logic                          status_tag_error
);

    localparam int CW = $clog2(TX_LIMIT + 1);

    typedef enum logic [1:0] {IDLE, ISSUE, STATUS} state_t;

    state_t                       state_q;
    logic [PW-1:0]                rr_q;
    logic [PW-1:0]                port_q;
    logic [PCIE_ADDR_WIDTH-1:0]   addr_q;
    logic [LEN_WIDTH-1:0]         rem_q;
    logic [LEN_WIDTH-1:0]         count_q;
    logic [TAG_WIDTH-1:0]         dtag_q;
    logic [12:0]                  bytes_q;
    logic [PCIE_TAG_COUNT-1:0]    free_q, free_d;
    logic [CW-1:0]                tx_q, tx_d;
    logic                         err_d;

    // Round robin: rr_q is the highest-priority port for the next grant.
    logic                         grant_vld_c;
    logic [PW-1:0]                grant_idx_c;
    always_comb begin
        grant_vld_c = 1'b0;
        grant_idx_c = '0;
        for (int j = 0; j < PORTS; j++) begin
            if (!grant_vld_c && j >= int'(rr_q) && s_axis_read_desc_valid[j]) begin
                grant_vld_c = 1'b1;
                grant_idx_c = PW'(j);
            end
        end
        for (int j = 0; j < PORTS; j++) begin
            if (!grant_vld_c && j < int'(rr_q) && s_axis_read_desc_valid[j]) begin
                grant_vld_c = 1'b1;
                grant_idx_c = PW'(j);
            end
        end
    end

    logic                         take_c;
    logic [PCIE_ADDR_WIDTH-1:0]   sel_addr_c;
    logic [LEN_WIDTH-1:0]         sel_len_c;
    logic [TAG_WIDTH-1:0]         sel_tag_c;
    assign take_c = !rst && state_q == IDLE && enable && grant_vld_c;
    always_comb begin
        sel_addr_c = '0;
        sel_len_c  = '0;
        sel_tag_c  = '0;
        s_axis_read_desc_ready = '0;
        for (int j = 0; j < PORTS; j++) begin
            if (grant_idx_c == PW'(j)) begin
                sel_addr_c = s_axis_read_desc_pcie_addr[j*PCIE_ADDR_WIDTH +: PCIE_ADDR_WIDTH];
                sel_len_c  = s_axis_read_desc_len[j*LEN_WIDTH +: LEN_WIDTH];
                sel_tag_c  = s_axis_read_desc_tag[j*TAG_WIDTH +: TAG_WIDTH];
                s_axis_read_desc_ready[j] = take_c;
            end
        end
    end

    // Request sizing: all three limits are at most 4096, so 13 bits suffice.
    logic [12:0] mrrs_c, bound_c, rem_c, bytes_c;
    logic [10:0] dw_c;
    logic [1:0]  end_lo_c;
    logic [3:0]  fbe_c, lbe_c;
    always_comb begin
        mrrs_c  = (max_read_request_size > 3'd5) ? 13'd4096
                                                 : (13'd128 << max_read_request_size);
        bound_c = 13'd4096 - {1'b0, addr_q[11:0]};
        rem_c   = (|rem_q[LEN_WIDTH-1:12]) ? 13'd4096 : {1'b0, rem_q[11:0]};
        bytes_c = rem_c;
        if (mrrs_c < bytes_c) bytes_c = mrrs_c;
        if (bound_c < bytes_c) bytes_c = bound_c;
        dw_c     = 11'(({11'd0, addr_q[1:0]} + bytes_c + 13'd3) >> 2);
        end_lo_c = addr_q[1:0] + bytes_c[1:0];
        fbe_c    = 4'hF << addr_q[1:0];
        lbe_c    = 4'hF >> (2'd0 - end_lo_c);
        if (dw_c == 11'd1) begin
            fbe_c = fbe_c & lbe_c;
            lbe_c = 4'h0;
        end
    end

    // Lowest eligible free tag; only tags 0..31 when extended tags are off.
    logic                      tag_avail_c;
    logic [PCIE_TAG_WIDTH-1:0] alloc_tag_c;
    always_comb begin
        tag_avail_c = 1'b0;
        alloc_tag_c = '0;
        for (int j = PCIE_TAG_COUNT - 1; j >= 0; j--) begin
            if (free_q[j] && (ext_tag_enable || j < 32)) begin
                tag_avail_c = 1'b1;
                alloc_tag_c = PCIE_TAG_WIDTH'(j);
            end
        end
    end

    logic fc_ok_c, alloc_c, accept_c;
    assign fc_ok_c  = (TX_FC_ENABLE == 0) || (pcie_tx_fc_nph_av >= 8'd2);
    assign alloc_c  = state_q == ISSUE && !m_axis_req_valid && tag_avail_c
                      && tx_q < CW'(TX_LIMIT) && fc_ok_c;
    assign accept_c = m_axis_req_valid && m_axis_req_ready;

    // Release checks free_q, so a same-cycle allocation never sees the
    // returning tag, and a double release is flagged rather than applied.
    always_comb begin
        free_d = free_q;
        err_d  = 1'b0;
        if (s_axis_tag_release_valid) begin
            if (free_q[s_axis_tag_release_tag]) err_d = 1'b1;
            else free_d[s_axis_tag_release_tag] = 1'b1;
        end
        if (alloc_c) free_d[alloc_tag_c] = 1'b0;
        tx_d = tx_q;
        if (accept_c && !tx_done) tx_d = tx_q + 1'b1;
        else if (!accept_c && tx_done && tx_q != '0) tx_d = tx_q - 1'b1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            free_q           <= '1;
            tx_q             <= '0;
            status_tag_error <= 1'b0;
        end else begin
            free_q           <= free_d;
            tx_q             <= tx_d;
            status_tag_error <= err_d;
        end
    end

    assign status_busy = state_q != IDLE;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q                   <= IDLE;
            rr_q                      <= '0;
            port_q                    <= '0;
            addr_q                    <= '0;
            rem_q                     <= '0;
            count_q                   <= '0;
            dtag_q                    <= '0;
            bytes_q                   <= '0;
            m_axis_req_pcie_addr      <= '0;
            m_axis_req_dword_count    <= '0;
            m_axis_req_first_be       <= '0;
            m_axis_req_last_be        <= '0;
            m_axis_req_pcie_tag       <= '0;
            m_axis_req_valid          <= 1'b0;
            m_axis_split_status_port  <= '0;
            m_axis_split_status_tag   <= '0;
            m_axis_split_status_count <= '0;
            m_axis_split_status_valid <= 1'b0;
        end else begin
            m_axis_split_status_valid <= 1'b0;
            unique case (state_q)
                IDLE: begin
                    if (take_c) begin
                        port_q  <= grant_idx_c;
                        rr_q    <= (grant_idx_c == PW'(PORTS - 1)) ? '0
                                                                   : grant_idx_c + 1'b1;
                        addr_q  <= sel_addr_c;
                        rem_q   <= sel_len_c;
                        dtag_q  <= sel_tag_c;
                        count_q <= '0;
                        if (sel_len_c == '0) begin
                            state_q                   <= STATUS;
                            m_axis_split_status_valid <= 1'b1;
                            m_axis_split_status_port  <= grant_idx_c;
                            m_axis_split_status_tag   <= sel_tag_c;
                            m_axis_split_status_count <= '0;
                        end else begin
                            state_q <= ISSUE;
                        end
                    end
                end
                ISSUE: begin
                    if (alloc_c) begin
                        m_axis_req_valid       <= 1'b1;
                        m_axis_req_pcie_addr   <= {addr_q[PCIE_ADDR_WIDTH-1:2], 2'b00};
                        m_axis_req_dword_count <= dw_c;
                        m_axis_req_first_be    <= fbe_c;
                        m_axis_req_last_be     <= lbe_c;
                        m_axis_req_pcie_tag    <= alloc_tag_c;
                        bytes_q                <= bytes_c;
                    end else if (accept_c) begin
                        m_axis_req_valid <= 1'b0;
                        addr_q  <= addr_q + PCIE_ADDR_WIDTH'(bytes_q);
                        rem_q   <= rem_q - LEN_WIDTH'(bytes_q);
                        count_q <= count_q + 1'b1;
                        if (rem_q == LEN_WIDTH'(bytes_q)) begin
                            state_q                   <= STATUS;
                            m_axis_split_status_valid <= 1'b1;
                            m_axis_split_status_port  <= port_q;
                            m_axis_split_status_tag   <= dtag_q;
                            m_axis_split_status_count <= count_q + 1'b1;
                        end
                    end
                end
                STATUS:  state_q <= IDLE;
                default: state_q <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_dma_pcie_rd_req_gen.sv
// Directed self-checking bench for dma_pcie_rd_req_gen (default parameters).
// Each scenario task drives stimulus and compares against hand-computed values.
module tb_dma_pcie_rd_req_gen;

    localparam int PORTS = 2;
    localparam int AW    = 64;
    localparam int LW    = 16;
    localparam int TW    = 8;
    localparam int GW    = 6;

    logic                clk = 1'b0;
    logic                rst;
    logic [PORTS*AW-1:0] d_addr;
    logic [PORTS*LW-1:0] d_len;
    logic [PORTS*TW-1:0] d_tag;
    logic [PORTS-1:0]    d_valid;
    logic [PORTS-1:0]    d_ready;
    logic [AW-1:0]       r_addr;
    logic [10:0]         r_dw;
    logic [3:0]          r_fbe, r_lbe;
    logic [GW-1:0]       r_tag;
    logic                r_valid, r_ready;
    logic [GW-1:0]       rel_tag;
    logic                rel_valid, tx_done;
    logic [7:0]          nph;
    logic                st_port;
    logic [TW-1:0]       st_tag;
    logic [LW-1:0]       st_count;
    logic                st_valid;
    logic                enable, ext_en;
    logic [2:0]          mrrs;
    logic                busy, tag_err;

    int checks = 0;
    int failures = 0;

    dma_pcie_rd_req_gen dut (
        .clk(clk), .rst(rst),
        .s_axis_read_desc_pcie_addr(d_addr),
        .s_axis_read_desc_len(d_len),
        .s_axis_read_desc_tag(d_tag),
        .s_axis_read_desc_valid(d_valid),
        .s_axis_read_desc_ready(d_ready),
        .m_axis_req_pcie_addr(r_addr),
        .m_axis_req_dword_count(r_dw),
        .m_axis_req_first_be(r_fbe),
        .m_axis_req_last_be(r_lbe),
        .m_axis_req_pcie_tag(r_tag),
        .m_axis_req_valid(r_valid),
        .m_axis_req_ready(r_ready),
        .s_axis_tag_release_tag(rel_tag),
        .s_axis_tag_release_valid(rel_valid),
        .tx_done(tx_done),
        .pcie_tx_fc_nph_av(nph),
        .m_axis_split_status_port(st_port),
        .m_axis_split_status_tag(st_tag),
        .m_axis_split_status_count(st_count),
        .m_axis_split_status_valid(st_valid),
        .enable(enable),
        .ext_tag_enable(ext_en),
        .max_read_request_size(mrrs),
        .status_busy(busy),
        .status_tag_error(tag_err)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        d_addr = '0; d_len = '0; d_tag = '0; d_valid = '0;
        r_ready = 1'b0; rel_tag = '0; rel_valid = 1'b0; tx_done = 1'b0;
        nph = 8'd8; enable = 1'b1; ext_en = 1'b1; mrrs = 3'd1;
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        tick();
    endtask

    task automatic send_desc(input int port, input logic [AW-1:0] a,
                             input logic [LW-1:0] l, input logic [TW-1:0] t);
        bit ok;
        ok = 1'b0;
        d_addr[port*AW +: AW] = a;
        d_len[port*LW +: LW]  = l;
        d_tag[port*TW +: TW]  = t;
        d_valid[port] = 1'b1;
        for (int c = 0; c < 20; c++) begin
            #1;
            if (d_ready[port]) begin
                ok = 1'b1;
                break;
            end
            tick();
        end
        if (ok) tick();
        d_valid[port] = 1'b0;
        checks++;
        if (!ok) begin
            failures++;
            $display("FAIL desc_accept port=%0d got ready=0 exp ready=1", port);
        end
    endtask

    task automatic get_req(input bit done, output logic [AW+GW+18:0] rec);
        bit ok;
        ok = 1'b0;
        rec = '0;
        r_ready = 1'b1;
        for (int c = 0; c < 50; c++) begin
            if (r_valid) begin
                ok = 1'b1;
                rec = {r_addr, r_dw, r_fbe, r_lbe, r_tag};
                tx_done = done;
                break;
            end
            tick();
        end
        if (ok) tick();
        r_ready = 1'b0;
        tx_done = 1'b0;
        checks++;
        if (!ok) begin
            failures++;
            $display("FAIL req_timeout got valid=0 exp valid=1");
        end
    endtask

    task automatic watch_valid(input int n, output bit seen);
        seen = 1'b0;
        r_ready = 1'b1;
        for (int c = 0; c < n; c++) begin
            if (r_valid) seen = 1'b1;
            tick();
        end
        r_ready = 1'b0;
    endtask

    task automatic test_reset();
        bit seen;
        do_reset();
        checks++;
        if ({r_valid, busy, st_valid, tag_err, d_ready} !== '0) begin
            failures++;
            $display("FAIL reset_ctrl got=%b exp=0",
                     {r_valid, busy, st_valid, tag_err, d_ready});
        end
        checks++;
        if ({r_addr, r_dw, r_fbe, r_lbe, r_tag, st_port, st_tag, st_count} !== '0) begin
            failures++;
            $display("FAIL reset_fields got=%h exp=0",
                     {r_addr, r_dw, r_fbe, r_lbe, r_tag, st_port, st_tag, st_count});
        end
        enable = 1'b0;
        d_valid[0] = 1'b1;
        seen = 1'b0;
        for (int c = 0; c < 5; c++) begin
            #1;
            if (d_ready !== 2'b00 || busy !== 1'b0) seen = 1'b1;
            tick();
        end
        checks++;
        if (seen) begin
            failures++;
            $display("FAIL disabled_grant got grant=1 exp grant=0");
        end
        enable = 1'b1;
        #1;
        checks++;
        if (d_ready !== 2'b01) begin
            failures++;
            $display("FAIL enable_grant got=%b exp=01", d_ready);
        end
        d_valid = '0;
    endtask

    task automatic test_split();
        logic [AW+GW+18:0] rec;
        do_reset();
        mrrs = 3'd1;
        send_desc(0, 64'h1000, 16'd512, 8'h11);
        checks++;
        if (busy !== 1'b1) begin
            failures++;
            $display("FAIL split_busy got=%b exp=1", busy);
        end
        get_req(1'b0, rec);
        checks++;
        if (rec !== {64'h1000, 11'd64, 4'hF, 4'hF, 6'd0}) begin
            failures++;
            $display("FAIL split_req0 got=%h exp=%h", rec,
                     {64'h1000, 11'd64, 4'hF, 4'hF, 6'd0});
        end
        get_req(1'b0, rec);
        checks++;
        if (rec !== {64'h1100, 11'd64, 4'hF, 4'hF, 6'd1}) begin
            failures++;
            $display("FAIL split_req1 got=%h exp=%h", rec,
                     {64'h1100, 11'd64, 4'hF, 4'hF, 6'd1});
        end
        checks++;
        if ({st_valid, st_port, st_tag, st_count} !== {1'b1, 1'b0, 8'h11, 16'd2}) begin
            failures++;
            $display("FAIL split_status got=%h exp=%h",
                     {st_valid, st_port, st_tag, st_count}, {1'b1, 1'b0, 8'h11, 16'd2});
        end
        tick();
        checks++;
        if (st_valid !== 1'b0) begin
            failures++;
            $display("FAIL status_pulse got=%b exp=0", st_valid);
        end
    endtask

    task automatic test_boundary();
        logic [AW+GW+18:0] rec;
        do_reset();
        send_desc(0, 64'h0FFE, 16'd8, 8'h22);
        get_req(1'b0, rec);
        checks++;
        if (rec !== {64'h0FFC, 11'd1, 4'hC, 4'h0, 6'd0}) begin
            failures++;
            $display("FAIL bound_req0 got=%h exp=%h", rec,
                     {64'h0FFC, 11'd1, 4'hC, 4'h0, 6'd0});
        end
        get_req(1'b0, rec);
        checks++;
        if (rec !== {64'h1000, 11'd2, 4'hF, 4'h3, 6'd1}) begin
            failures++;
            $display("FAIL bound_req1 got=%h exp=%h", rec,
                     {64'h1000, 11'd2, 4'hF, 4'h3, 6'd1});
        end
        checks++;
        if ({st_valid, st_tag, st_count} !== {1'b1, 8'h22, 16'd2}) begin
            failures++;
            $display("FAIL bound_status got=%h exp=%h",
                     {st_valid, st_tag, st_count}, {1'b1, 8'h22, 16'd2});
        end
    endtask

    task automatic test_round_robin();
        logic [3:0]  gseq;
        logic [31:0] stq;
        logic [1:0]  prev;
        int grants, bad;
        bit drop;
        do_reset();
        gseq = '0; stq = '0; prev = '0; grants = 0; bad = 0; drop = 1'b0;
        d_len = '0;
        d_tag = {8'hB1, 8'hA0};
        d_valid = 2'b11;
        for (int c = 0; c < 12; c++) begin
            if (drop) d_valid = 2'b00;
            #1;
            if (st_valid) stq = {stq[23:0], st_tag};
            if (d_ready !== 2'b00) begin
                if (d_ready !== 2'b01 && d_ready !== 2'b10) bad++;
                if (prev !== 2'b00) bad++;
                gseq = {gseq[2:0], d_ready[1]};
                grants++;
                if (grants == 4) drop = 1'b1;
            end
            prev = d_ready;
            tick();
        end
        checks++;
        if (grants != 4 || gseq !== 4'b0101) begin
            failures++;
            $display("FAIL rr_order got=%0d/%b exp=4/0101", grants, gseq);
        end
        checks++;
        if (bad != 0) begin
            failures++;
            $display("FAIL rr_pulse got=%0d exp=0", bad);
        end
        checks++;
        if (stq !== 32'hA0B1A0B1) begin
            failures++;
            $display("FAIL rr_status got=%h exp=a0b1a0b1", stq);
        end
    endtask

    task automatic test_tag_pool();
        logic [AW+GW+18:0] rec;
        bit seen;
        do_reset();
        ext_en = 1'b0;
        for (int i = 0; i < 32; i++) begin
            send_desc(0, 64'(i * 4), 16'd4, 8'(i));
            get_req(1'b1, rec);
            checks++;
            if (rec !== {64'(i * 4), 11'd1, 4'hF, 4'h0, 6'(i)}) begin
                failures++;
                $display("FAIL pool_req%0d got=%h exp=%h", i, rec,
                         {64'(i * 4), 11'd1, 4'hF, 4'h0, 6'(i)});
            end
        end
        send_desc(0, 64'h200, 16'd4, 8'h33);
        watch_valid(10, seen);
        checks++;
        if (seen) begin
            failures++;
            $display("FAIL pool_stall got valid=1 exp valid=0");
        end
        rel_tag = 6'd5;
        rel_valid = 1'b1;
        tick();
        checks++;
        if (tag_err !== 1'b0) begin
            failures++;
            $display("FAIL release_ok got=%b exp=0", tag_err);
        end
        tick();
        rel_valid = 1'b0;
        checks++;
        if (tag_err !== 1'b1) begin
            failures++;
            $display("FAIL double_release got=%b exp=1", tag_err);
        end
        get_req(1'b1, rec);
        checks++;
        if (rec !== {64'h200, 11'd1, 4'hF, 4'h0, 6'd5}) begin
            failures++;
            $display("FAIL reuse_tag got=%h exp=%h", rec,
                     {64'h200, 11'd1, 4'hF, 4'h0, 6'd5});
        end
        checks++;
        if (tag_err !== 1'b0) begin
            failures++;
            $display("FAIL tag_err_pulse got=%b exp=0", tag_err);
        end
        ext_en = 1'b1;
    endtask

    task automatic test_tx_limit();
        logic [AW+GW+18:0] rec;
        bit seen;
        do_reset();
        mrrs = 3'd0;
        send_desc(0, 64'h0, 16'd1280, 8'h55);
        for (int i = 0; i < 8; i++) begin
            get_req(1'b0, rec);
            checks++;
            if (rec !== {64'(i * 128), 11'd32, 4'hF, 4'hF, 6'(i)}) begin
                failures++;
                $display("FAIL tx_req%0d got=%h exp=%h", i, rec,
                         {64'(i * 128), 11'd32, 4'hF, 4'hF, 6'(i)});
            end
        end
        watch_valid(10, seen);
        checks++;
        if (seen) begin
            failures++;
            $display("FAIL tx_stall got valid=1 exp valid=0");
        end
        tx_done = 1'b1;
        tick();
        tx_done = 1'b0;
        get_req(1'b0, rec);
        checks++;
        if (rec !== {64'h400, 11'd32, 4'hF, 4'hF, 6'd8}) begin
            failures++;
            $display("FAIL tx_one_more got=%h exp=%h", rec,
                     {64'h400, 11'd32, 4'hF, 4'hF, 6'd8});
        end
        watch_valid(10, seen);
        checks++;
        if (seen) begin
            failures++;
            $display("FAIL tx_only_one got valid=1 exp valid=0");
        end
        nph = 8'd1;
        tx_done = 1'b1;
        tick();
        tx_done = 1'b0;
        watch_valid(10, seen);
        checks++;
        if (seen) begin
            failures++;
            $display("FAIL nph_stall got valid=1 exp valid=0");
        end
        nph = 8'd2;
        get_req(1'b0, rec);
        checks++;
        if (rec !== {64'h480, 11'd32, 4'hF, 4'hF, 6'd9}) begin
            failures++;
            $display("FAIL nph_resume got=%h exp=%h", rec,
                     {64'h480, 11'd32, 4'hF, 4'hF, 6'd9});
        end
        checks++;
        if ({st_valid, st_tag, st_count} !== {1'b1, 8'h55, 16'd10}) begin
            failures++;
            $display("FAIL tx_status got=%h exp=%h",
                     {st_valid, st_tag, st_count}, {1'b1, 8'h55, 16'd10});
        end
    endtask

    task automatic test_reset_mid();
        logic [AW+GW+18:0] rec;
        bit seen;
        do_reset();
        send_desc(0, 64'h2000, 16'd512, 8'h66);
        get_req(1'b0, rec);
        seen = 1'b0;
        for (int c = 0; c < 10; c++) begin
            if (r_valid) begin
                seen = 1'b1;
                break;
            end
            tick();
        end
        checks++;
        if (!seen || r_tag !== 6'd1) begin
            failures++;
            $display("FAIL mid_pending got=%b/%0d exp=1/1", seen, r_tag);
        end
        rst = 1'b1;
        tick();
        checks++;
        if ({r_valid, busy, st_valid} !== 3'b000) begin
            failures++;
            $display("FAIL mid_reset got=%b exp=000", {r_valid, busy, st_valid});
        end
        rst = 1'b0;
        seen = 1'b0;
        for (int c = 0; c < 5; c++) begin
            if (st_valid) seen = 1'b1;
            tick();
        end
        checks++;
        if (seen) begin
            failures++;
            $display("FAIL mid_no_status got=1 exp=0");
        end
        send_desc(1, 64'h3000, 16'd4, 8'h77);
        get_req(1'b0, rec);
        checks++;
        if (rec !== {64'h3000, 11'd1, 4'hF, 4'h0, 6'd0}) begin
            failures++;
            $display("FAIL mid_tags_free got=%h exp=%h", rec,
                     {64'h3000, 11'd1, 4'hF, 4'h0, 6'd0});
        end
        checks++;
        if ({st_valid, st_port, st_tag, st_count} !== {1'b1, 1'b1, 8'h77, 16'd1}) begin
            failures++;
            $display("FAIL mid_status got=%h exp=%h",
                     {st_valid, st_port, st_tag, st_count}, {1'b1, 1'b1, 8'h77, 16'd1});
        end
    endtask

    initial begin
        test_reset();
        test_split();
        test_boundary();
        test_round_robin();
        test_tag_pool();
        test_tx_limit();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
